c_wait_merge_sync_n: RTL
========================

// Module: c_wait_merge_sync_n
// PURPOSE
//  Clocked, parametrised N-channel wait-merge (join) for the drive/free handshake fabric.
//  - Collects one token per enabled channel and registers each channel's data.
//  - Fires one merged token downstream, then holds the merged data until downstream frees it.
//  - Returns free to every participating channel.
//  - Adds a runtime channel mask, overrun/spurious-free error flags and a merge counter.
//  - Used where handshake joins cross into the synchronous domain.
// PARAMETERS
//  N_CH    5  number of input channels (>=2)
//  DATA_W  3  data width per channel
//  CNT_W   8  width of completed-merge counter (wraps)
// PORTS
//  clk          in   1            single clock, rising edge
//  rst          in   1            asynchronous, active-high reset
//  i_drive      in   N_CH         per-channel drive; 1-cycle pulse per token
//  i_data       in   N_CH*DATA_W  channel k at [k*DATA_W +: DATA_W], valid with i_drive[k]
//  i_mask       in   N_CH         1 = channel participates; sampled while in COLLECT
//  o_free       out  N_CH         per-channel free, 1-cycle pulse
//  o_driveNext  out  1            merged token, 1-cycle pulse
//  o_data       out  N_CH*DATA_W  merged data; stable from o_driveNext until o_free
//  i_freeNext   in   1            downstream free, 1-cycle pulse
//  o_err        out  2            sticky flags: [0] overrun, [1] spurious free
//  o_mergeCnt   out  CNT_W        number of completed merges
// BEHAVIOUR
//  Reset (async, any time):
//  - State returns to COLLECT; pend, mask_q, data regs, o_err, o_mergeCnt cleared.
//  - All outputs are 0.
//  - An in-flight merge is aborted and no o_free is issued for it.
//  States:
//  - COLLECT -> FIRE -> WAIT_FREE -> RELEASE -> COLLECT.
//  COLLECT:
//  - Participating set is i_mask.
//  - i_drive[k] & i_mask[k] & ~pend[k]: set pend[k] and capture the data slice.
//  - i_drive[k] & ~i_mask[k]: drop the data; o_free[k] pulses the next cycle (pass-through ack).
//  - i_drive[k] & pend[k]: set o_err[0]; keep the original data.
//  - When (pend_next | ~i_mask) is all ones and i_mask != 0:
//    - latch mask_q = i_mask and go to FIRE.
//    - If the last drive arrives at edge t, o_driveNext is high during cycle t+1.
//  - i_mask == 0: never fire; every drive is pass-through acked.
//  FIRE:
//  - o_driveNext = 1 for exactly one cycle, then WAIT_FREE.
//  - o_data is valid from this cycle. Slots of masked channels read 0.
//  WAIT_FREE:
//  - Hold o_data.
//  - Drives on pend channels set o_err[0] and are dropped, including in the same cycle as i_freeNext.
//  - Drives on ~mask_q channels are pass-through acked.
//  - i_freeNext seen in FIRE or WAIT_FREE -> RELEASE.
//  RELEASE (1 cycle):
//  - o_free[k] = pend[k] for all k.
//  - Clear pend; o_mergeCnt += 1 (wraps at 2^CNT_W); go to COLLECT.
//  - New drives here are captured as in COLLECT.
//  - Minimum cycle: last drive -> driveNext -> freeNext -> o_free is 3 cycles when freeNext returns immediately.
//  Spurious free:
//  - i_freeNext in COLLECT or RELEASE sets o_err[1] and is otherwise ignored.
//  Errors:
//  - o_err clears only on reset.
//  - Handshake outputs are registered; no combinational in->out path.
// TESTING
//  1. Drives on ch0..4 in cycles 1..5, data k+1, mask=5'h1F, freeNext 2 cycles after driveNext
//     -> one driveNext pulse; o_data=15'o54321; o_free=5'h1F for 1 cycle; cnt=1.
//  2. All 5 drives in the same cycle -> driveNext exactly 1 cycle later; no err.
//  3. mask=5'b00101; drives on ch0,1,2
//     -> ch1 o_free next cycle; merge fires on ch0+ch2; ch1 slot=0; o_free=5'b00101.
//  4. Second drive on ch3 before free
//     -> o_err[0]=1; o_data unchanged; only one o_free[3] pulse.
//  5. freeNext while idle -> o_err[1]=1; no o_free, cnt unchanged.
//  6. rst mid-WAIT_FREE
//     -> outputs 0, no o_free; next full token set merges normally with cnt=1.

Source files
------------

// File: rtl/c_wait_merge_sync_n.sv
// rtl/c_wait_merge_sync_n.sv - clocked N-channel wait-merge (join) with mask, error flags and merge counter
module c_wait_merge_sync_n #(
    parameter int N_CH   = 5,
    parameter int DATA_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          i_drive,
    input  logic [N_CH*DATA_W-1:0]   i_data,
    input  logic [N_CH-1:0]          i_mask,
    output logic [N_CH-1:0]          o_free,
    output logic                     o_driveNext,
    output logic [N_CH*DATA_W-1:0]   o_data,
    input  logic                     i_freeNext,
    output logic [1:0]               o_err,
    output logic [CNT_W-1:0]         o_mergeCnt
);

    typedef enum logic [1:0] {
        COLLECT   = 2'd0,
        FIRE      = 2'd1,
        WAIT_FREE = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    state_t                   state;
    logic [N_CH-1:0]          pend;
    logic [N_CH-1:0]          mask_q;
    logic [N_CH*DATA_W-1:0]   data_q;

    logic [N_CH-1:0]          pend_base;
    logic [N_CH-1:0]          pend_next;
    logic [N_CH-1:0]          capture;
    logic [N_CH-1:0]          pass_ack;
    logic [N_CH-1:0]          overrun;
    logic                     fire;

    // Classify every incoming drive: capture into a free slot, ack straight back, or flag overrun.
    // RELEASE behaves like COLLECT but against an already-cleared pending set.
    always_comb begin
        pend_base = '0;
        pend_next = pend;
        capture   = '0;
        pass_ack  = '0;
        overrun   = '0;
        fire      = 1'b0;
        case (state)
            COLLECT, RELEASE: begin
                pend_base = (state == RELEASE) ? '0 : pend;
                pend_next = pend_base;
                for (int k = 0; k < N_CH; k++) begin
                    if (i_drive[k]) begin
                        if (!i_mask[k]) begin
                            pass_ack[k] = 1'b1;
                        end else if (pend_base[k]) begin
                            overrun[k] = 1'b1;
                        end else begin
                            capture[k]   = 1'b1;
                            pend_next[k] = 1'b1;
                        end
                    end
                end
                fire = (state == COLLECT) && (&(pend_next | ~i_mask)) && (|i_mask);
            end
            FIRE, WAIT_FREE: begin
                for (int k = 0; k < N_CH; k++) begin
                    if (i_drive[k]) begin
                        if (pend[k]) begin
                            overrun[k] = 1'b1;
                        end else begin
                            pass_ack[k] = 1'b1;
                        end
                    end
                end
            end
            default: begin
                pend_next = pend;
            end
        endcase
    end

    // Merge FSM with registered handshake outputs, data capture, sticky errors and counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= COLLECT;
            pend        <= '0;
            mask_q      <= '0;
            data_q      <= '0;
            o_free      <= '0;
            o_driveNext <= 1'b0;
            o_err       <= 2'b00;
            o_mergeCnt  <= '0;
        end else begin
            o_free      <= pass_ack | ((state == RELEASE) ? pend : '0);
            o_driveNext <= 1'b0;
            pend        <= pend_next;
            if (|overrun) begin
                o_err[0] <= 1'b1;
            end
            for (int k = 0; k < N_CH; k++) begin
                if (capture[k]) begin
                    data_q[k*DATA_W +: DATA_W] <= i_data[k*DATA_W +: DATA_W];
                end
            end
            case (state)
                COLLECT: begin
                    if (i_freeNext) begin
                        o_err[1] <= 1'b1;
                    end
                    if (fire) begin
                        mask_q      <= i_mask;
                        o_driveNext <= 1'b1;
                        state       <= FIRE;
                    end
                end
                FIRE: begin
                    state <= i_freeNext ? RELEASE : WAIT_FREE;
                end
                WAIT_FREE: begin
                    if (i_freeNext) begin
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (i_freeNext) begin
                        o_err[1] <= 1'b1;
                    end
                    o_mergeCnt <= o_mergeCnt + CNT_W'(1);
                    state      <= COLLECT;
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

    // Present merged data with slots of non-participating channels forced to zero.
    always_comb begin
        o_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            o_data[k*DATA_W +: DATA_W] = mask_q[k] ? data_q[k*DATA_W +: DATA_W] : '0;
        end
    end

endmodule
